// File: rtl/mux_n_pipe.sv
// N-way word selector built as a binary tree of 2:1 muxes with a valid/ready pipeline.
// Define MUX_N_PIPE_STAGE_EN to register every tree level; otherwise one output register.
module mux_n_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

`ifdef MUX_N_PIPE_STAGE_EN
  localparam bit STAGED = 1'b1;
`else
  localparam bit STAGED = 1'b0;
`endif

  logic adv;

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  // Level j halves the word count using sel bit j; the full sel rides along for out_sel.
  for (genvar j = 0; j < SELW; j++) begin : lvl
    localparam int unsigned CNT = N >> (j + 1);

    logic [2*CNT*WIDTH-1:0] src_d;
    logic                   src_v;
    logic [SELW-1:0]        src_s;
    logic [CNT*WIDTH-1:0]   mux_d;
    logic                   v;
    logic [CNT*WIDTH-1:0]   d;
    logic [SELW-1:0]        s;

    if (j == 0) begin : g_src
      assign src_v = in_valid;
      assign src_d = in_data;
      assign src_s = in_sel;
    end else begin : g_src
      assign src_v = lvl[j-1].v;
      assign src_d = lvl[j-1].d;
      assign src_s = lvl[j-1].s;
    end

    always_comb begin
      mux_d = '0;
      for (int unsigned k = 0; k < CNT; k++) begin
        mux_d[k*WIDTH +: WIDTH] = src_s[j] ? src_d[(2*k+1)*WIDTH +: WIDTH]
                                           : src_d[(2*k)*WIDTH +: WIDTH];
      end
    end

    if (STAGED) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v <= 1'b0;
          d <= '0;
          s <= '0;
        end else if (adv) begin
          v <= src_v;
          d <= mux_d;
          s <= src_s;
        end
      end
    end else begin : g_wire
      assign v = src_v;
      assign d = mux_d;
      assign s = src_s;
    end
  end

  if (STAGED) begin : g_out
    assign out_valid = lvl[SELW-1].v;
    assign out_data  = lvl[SELW-1].d;
    assign out_sel   = lvl[SELW-1].s;
  end else begin : g_out
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_valid <= 1'b0;
        out_data  <= '0;
        out_sel   <= '0;
      end else if (adv) begin
        out_valid <= lvl[SELW-1].v;
        out_data  <= lvl[SELW-1].d;
        out_sel   <= lvl[SELW-1].s;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed checks of mux_n_pipe (N=4, WIDTH=64) plus a random scoreboard run (N=8, WIDTH=16).
// Latency expectations follow MUX_N_PIPE_STAGE_EN.
module tb_mux_n_pipe;

`ifdef MUX_N_PIPE_STAGE_EN
  localparam int LAT1 = 2;
`else
  localparam int LAT1 = 1;
`endif

  logic         clk;
  logic         rst;

  logic         a_valid, a_irdy, a_ovalid, a_ordy;
  logic [255:0] a_data;
  logic [1:0]   a_sel, a_osel;
  logic [63:0]  a_odata;

  logic         b_valid, b_irdy, b_ovalid, b_ordy;
  logic [127:0] b_data;
  logic [2:0]   b_sel, b_osel;
  logic [15:0]  b_odata;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] word_tab [4] = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
  int          seq  [5]     = '{0, 1, 2, 3, 0};
  logic [63:0] expd [5]     = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA0};
  int          seq2 [4]     = '{3, 1, 2, 0};
  logic [63:0] exp2 [4]     = '{64'hA3, 64'hA1, 64'hA2, 64'hA0};

  logic [18:0] sbq [$];

  mux_n_pipe #(.WIDTH(64), .N(4)) u_dut_a (
    .clk(clk), .reset(rst),
    .in_valid(a_valid), .in_ready(a_irdy), .in_data(a_data), .in_sel(a_sel),
    .out_valid(a_ovalid), .out_ready(a_ordy), .out_data(a_odata), .out_sel(a_osel)
  );

  mux_n_pipe #(.WIDTH(16), .N(8)) u_dut_b (
    .clk(clk), .reset(rst),
    .in_valid(b_valid), .in_ready(b_irdy), .in_data(b_data), .in_sel(b_sel),
    .out_valid(b_ovalid), .out_ready(b_ordy), .out_data(b_odata), .out_sel(b_osel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    int e;
    int m;
    int sent;
    int got;
    logic [18:0] ent;

    rst     = 1'b1;
    a_valid = 1'b0;
    a_sel   = '0;
    a_ordy  = 1'b1;
    a_data  = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    b_valid = 1'b0;
    b_data  = '0;
    b_sel   = '0;
    b_ordy  = 1'b0;
    #2;
    check("rst_out_valid", 64'(a_ovalid), 0);
    check("rst_out_data",  a_odata, 0);
    check("rst_out_sel",   64'(a_osel), 0);
    check("rst_in_ready",  64'(a_irdy), 1);

    // Requests offered while reset is high must not be captured.
    a_valid = 1'b1;
    a_sel   = 2'd2;
    tick();
    tick();
    check("rst_no_capture", 64'(a_ovalid), 0);
    a_valid = 1'b0;
    rst     = 1'b0;
    for (int c = 1; c <= LAT1 + 1; c++) begin
      tick();
      check("post_rst_idle", 64'(a_ovalid), 0);
    end

    // Single request, sel=2.
    a_valid = 1'b1;
    a_sel   = 2'd2;
    tick();
    a_valid = 1'b0;
    for (int c = 1; c <= LAT1; c++) begin
      if (c > 1) tick();
      if (c < LAT1) check("single_wait", 64'(a_ovalid), 0);
    end
    check("single_valid", 64'(a_ovalid), 1);
    check("single_data",  a_odata, 64'hA2);
    check("single_sel",   64'(a_osel), 2);
    tick();
    check("single_retire", 64'(a_ovalid), 0);

    // Back-to-back stream.
    for (int c = 1; c <= 4 + LAT1; c++) begin
      if (c <= 5) begin
        a_valid = 1'b1;
        a_sel   = 2'(seq[c-1]);
      end else begin
        a_valid = 1'b0;
      end
      tick();
      idx = c - LAT1;
      if (idx >= 0 && idx < 5) begin
        check("stream_valid", 64'(a_ovalid), 1);
        check("stream_data",  a_odata, expd[idx]);
        check("stream_sel",   64'(a_osel), 64'(seq[idx]));
      end
    end
    a_valid = 1'b0;
    tick();
    check("stream_end", 64'(a_ovalid), 0);

    // Fill with out_ready low, hold for 3 cycles, then drain in order.
    a_ordy = 1'b0;
    idx = 0;
    for (int c = 1; c <= LAT1; c++) begin
      a_valid = 1'b1;
      a_sel   = 2'(seq2[idx]);
      #1;
      check("fill_in_ready", 64'(a_irdy), 1);
      tick();
      idx++;
    end
    a_sel = 2'(seq2[idx]);
    #1;
    check("full_in_ready", 64'(a_irdy), 0);
    check("full_valid", 64'(a_ovalid), 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_in_ready", 64'(a_irdy), 0);
      check("stall_data", a_odata, exp2[0]);
      check("stall_sel", 64'(a_osel), 64'(seq2[0]));
    end
    a_ordy = 1'b1;
    e = 0;
    for (int c = 0; c < 20 && e < 4; c++) begin
      if (idx < 4) begin
        a_valid = 1'b1;
        a_sel   = 2'(seq2[idx]);
      end else begin
        a_valid = 1'b0;
      end
      #1;
      if (a_ovalid && a_ordy) begin
        check("drain_data", a_odata, exp2[e]);
        check("drain_sel", 64'(a_osel), 64'(seq2[e]));
        e++;
      end
      if (a_valid && a_irdy) idx++;
      tick();
    end
    check("drain_count", 64'(e), 4);
    a_valid = 1'b0;
    tick();

    // Reset with requests in flight.
    a_valid = 1'b1;
    a_sel   = 2'd1;
    tick();
    a_sel   = 2'd3;
    tick();
    a_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(a_ovalid), 0);
    check("midrst_data",  a_odata, 0);
    check("midrst_sel",   64'(a_osel), 0);
    tick();
    rst = 1'b0;
    for (int c = 1; c <= LAT1 + 2; c++) begin
      tick();
      check("post_midrst_stale", 64'(a_ovalid), 0);
    end

    // Alternating valid: bubbles must come out as out_valid=0.
    for (int c = 1; c <= 7 + LAT1; c++) begin
      if (c <= 8) begin
        a_valid = (c % 2) == 1;
        a_sel   = 2'((c >> 1) & 3);
      end else begin
        a_valid = 1'b0;
      end
      tick();
      m = c - LAT1 + 1;
      if (m >= 1 && m <= 8) begin
        check("alt_valid", 64'(a_ovalid), 64'(m % 2));
        if ((m % 2) == 1) check("alt_data", a_odata, word_tab[(m >> 1) & 3]);
      end
    end
    a_valid = 1'b0;

    // Random traffic on the N=8 instance against a queue of expected words.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 8000 && got < 1000; c++) begin
      b_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b_data  = {$urandom, $urandom, $urandom, $urandom};
      b_sel   = 3'($urandom_range(0, 7));
      b_ordy  = $urandom_range(0, 3) != 0;
      #1;
      if (b_ovalid && b_ordy) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected", 64'(b_ovalid), 0);
        end else begin
          ent = sbq.pop_front();
          check("sb_data", 64'(b_odata), 64'(ent[15:0]));
          check("sb_sel",  64'(b_osel),  64'(ent[18:16]));
        end
        got++;
      end
      if (b_valid && b_irdy) begin
        sbq.push_back({b_sel, b_data[b_sel*16 +: 16]});
        sent++;
      end
      tick();
    end
    check("sb_count", 64'(got), 1000);
    check("sb_leftover", 64'(sbq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
